// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Purpose:
//    Measures an incoming PWM waveform and reports its high time and period
//    in clk cycles. Receive-side counterpart of the PWM generator, whose
//    nominal period is 2**resolution clocks and whose high time equals its
//    duty value. pwm_in is asynchronous to clk and is synchronised here.
//
//    A measurement is published on every rising edge of the (synchronised)
//    input once a reference edge has been seen. If no rising edge arrives
//    within 2**(resolution+1) clocks, a timeout result is published
//    (period_out = 0, duty_out = full or zero depending on the static level),
//    stuck is raised, and the block re-arms. The timeout repeats every
//    2**(resolution+1) clocks while the line stays static.
//
// Parameters:
//    resolution  duty resolution in bits (default 4)
//
// Ports:
//    clk         in   1               system clock, rising edge
//    reset       in   1               asynchronous, active-high reset
//    pwm_in      in   1               PWM waveform, asynchronous to clk
//    duty_out    out  resolution+1    high cycles of the last period
//    period_out  out  resolution+2    cycles between rising edges, 0 on timeout
//    done        out  1               one-cycle pulse when outputs update
//    stuck       out  1               high while no rising edge within timeout
//
// Build option:
//    PWM_CAPTURE_GLITCH_FILTER_EN  when defined, a two-sample agreement
//    filter follows the synchroniser so single-cycle pulses of either
//    polarity are ignored. Adds one cycle of latency to done; clean
//    waveform measurements are unchanged because both edges shift equally.
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int resolution = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pwm_in,
   output logic [resolution:0]   duty_out,
   output logic [resolution+1:0] period_out,
   output logic                  done,
   output logic                  stuck
);

   localparam int CW = resolution + 2;

   // 2**(resolution+1): timeout threshold and counter saturation value
   localparam logic [CW-1:0] TIMEOUT = {1'b1, {(resolution + 1){1'b0}}};
   // 2**resolution: duty reported when the line times out while high
   localparam logic [resolution:0] FULL_DUTY = {1'b1, {resolution{1'b0}}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW - 1){1'b0}}, 1'b1};

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   // --------------------------------------------------------------------------
   // Input synchroniser
   // --------------------------------------------------------------------------
   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= pwm_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // --------------------------------------------------------------------------
   // Edge / level extraction
   // --------------------------------------------------------------------------
   logic rise;
   logic level;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   // filt_q is the last accepted level. A new level is accepted only when two
   // consecutive synchronised samples (s3_q, s2_q) agree and differ from it.
   // The accepted level is taken from filt_d so that the filter costs exactly
   // one cycle; filt_q then serves as its delayed copy for edge detection.
   logic filt_q, filt_d;

   always_comb begin
      filt_d = filt_q;
      if ((s2_q == s3_q) && (s2_q != filt_q)) begin
         filt_d = s2_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q <= 1'b0;
      end else begin
         filt_q <= filt_d;
      end
   end

   assign level = filt_d;
   assign rise  = filt_d & ~filt_q;
`else
   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;
`endif

   // --------------------------------------------------------------------------
   // Measurement state
   // --------------------------------------------------------------------------
   logic [0:0]          state_q, state_d;
   logic [CW-1:0]       period_cnt_q, period_cnt_d;
   logic [CW-1:0]       high_cnt_q, high_cnt_d;
   logic [resolution:0] duty_q, duty_d;
   logic [CW-1:0]       period_q, period_d;
   logic                done_q, done_d;
   logic                stuck_q, stuck_d;

   logic [CW-1:0] period_inc;
   logic [CW-1:0] high_inc;
   logic          timeout_hit;

   // Both counters saturate at the timeout value so they never wrap back
   // into a plausible-looking measurement.
   assign period_inc  = (period_cnt_q == TIMEOUT) ? TIMEOUT : period_cnt_q + CNT_ONE;
   assign high_inc    = (high_cnt_q   == TIMEOUT) ? TIMEOUT : high_cnt_q   + CNT_ONE;
   assign timeout_hit = (period_cnt_q == TIMEOUT);

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_inc;
      high_cnt_d   = level ? high_inc : high_cnt_q;
      duty_d       = duty_q;
      period_d     = period_q;
      done_d       = 1'b0;
      stuck_d      = stuck_q;

      if (rise) begin
         // The rising-edge cycle is the first cycle of the new period and
         // the first high cycle, hence the restart value of 1.
         period_cnt_d = CNT_ONE;
         high_cnt_d   = CNT_ONE;
         if (state_q == ST_IDLE) begin
            // First edge only establishes the reference; nothing to report.
            state_d = ST_MEASURE;
         end else begin
            duty_d   = high_cnt_q[resolution:0];
            period_d = period_cnt_q;
            done_d   = 1'b1;
            stuck_d  = 1'b0;
         end
      end else if (timeout_hit) begin
         // Static line: report full or zero duty, then drop back to IDLE so
         // the next edge is treated as a fresh reference.
         duty_d       = level ? FULL_DUTY : '0;
         period_d     = '0;
         done_d       = 1'b1;
         stuck_d      = 1'b1;
         period_cnt_d = CNT_ONE;
         state_d      = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         duty_q       <= '0;
         period_q     <= '0;
         done_q       <= 1'b0;
         stuck_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         duty_q       <= duty_d;
         period_q     <= period_d;
         done_q       <= done_d;
         stuck_q      <= stuck_d;
      end
   end

   assign duty_out   = duty_q;
   assign period_out = period_q;
   assign done       = done_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed testbench for pwm_capture (resolution = 4). Drives pwm_in on the
// falling edge of clk, records every done pulse (cycle stamp and outputs) on
// the falling edge, and compares against hand-computed expectations.
// Honours PWM_CAPTURE_GLITCH_FILTER_EN for latency and glitch expectations.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int RES = 4;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT  = 4;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit FILT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           pwm_in;
   logic [RES:0]   duty_out;
   logic [RES+1:0] period_out;
   logic           done;
   logic           stuck;

   int total = 0;
   int bad   = 0;

   pwm_capture #(.resolution(RES)) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .duty_out   (duty_out),
      .period_out (period_out),
      .done       (done),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used as a time stamp
   int pcnt = 0;
   always @(posedge clk) pcnt++;

   // done-pulse recorder
   int   ev_stamp[$];
   int   ev_duty[$];
   int   ev_period[$];
   int   ev_stuck[$];
   int   rise_stamp[$];
   int   wide_err = 0;
   logic done_prev = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         ev_stamp.push_back(pcnt);
         ev_duty.push_back(int'(duty_out));
         ev_period.push_back(int'(period_out));
         ev_stuck.push_back(int'(stuck));
         $display("done @%0d duty_out=%0d period_out=%0d stuck=%0d",
                  pcnt, duty_out, period_out, stuck);
      end
      if (done === 1'b1 && done_prev === 1'b1) wide_err++;
      done_prev = done;
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_ev(input string tag, input int i, input int d, input int p, input int s);
      if (i < ev_duty.size()) begin
         check($sformatf("%s%0d_duty", tag, i),   ev_duty[i],   d);
         check($sformatf("%s%0d_period", tag, i), ev_period[i], p);
         check($sformatf("%s%0d_stuck", tag, i),  ev_stuck[i],  s);
      end else begin
         check($sformatf("%s%0d_missing", tag, i), ev_duty.size(), i + 1);
      end
   endtask

   task automatic clear_events();
      ev_stamp.delete();
      ev_duty.delete();
      ev_period.delete();
      ev_stuck.delete();
      rise_stamp.delete();
   endtask

   task automatic hold(input int n, input logic v);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         pwm_in = v;
      end
   endtask

   // One PWM period of p cycles, high for h; glitch_at >= 0 adds a 1-cycle
   // high pulse at that offset.
   task automatic pwm_period(input int p, input int h, input int glitch_at);
      for (int c = 0; c < p; c++) begin
         @(negedge clk);
         if (c == 0) rise_stamp.push_back(pcnt);
         pwm_in = (c < h) || (c == glitch_at);
      end
   endtask

   int rel_stamp;

   initial begin
      reset  = 1'b1;
      pwm_in = 1'b0;

      // ---------------- reset state
      repeat (3) @(negedge clk);
      check("rst_duty",   int'(duty_out),   0);
      check("rst_period", int'(period_out), 0);
      check("rst_done",   int'(done),       0);
      check("rst_stuck",  int'(stuck),      0);

      // ---------------- line held low from reset: timeouts every 32
      @(negedge clk);
      reset     = 1'b0;
      rel_stamp = pcnt;
      hold(70, 1'b0);
      #1;
      check("lo_ndone", ev_duty.size(), 2);
      check_ev("lo", 0, 0, 0, 1);
      check_ev("lo", 1, 0, 0, 1);
      if (ev_stamp.size() >= 2) begin
         check("lo_first", ev_stamp[0] - rel_stamp, 33);
         check("lo_gap",   ev_stamp[1] - ev_stamp[0], 32);
      end
      check("lo_stuck", int'(stuck), 1);

      // ---------------- 16/4 stream: first rise arms, then done every 16
      clear_events();
      repeat (4) pwm_period(16, 4, -1);
      #1;
      check("p4_ndone", ev_duty.size(), 3);
      check_ev("p4", 0, 4, 16, 0);
      check_ev("p4", 1, 4, 16, 0);
      check_ev("p4", 2, 4, 16, 0);
      if (ev_stamp.size() >= 2 && rise_stamp.size() >= 2) begin
         check("p4_latency", ev_stamp[0] - rise_stamp[1], LAT);
         check("p4_gap",     ev_stamp[1] - ev_stamp[0],   16);
      end
      check("p4_stuck", int'(stuck), 0);

      // ---------------- duty switched 4 -> 12
      clear_events();
      repeat (2) pwm_period(16, 12, -1);
      #1;
      check("p12_ndone", ev_duty.size(), 2);
      check_ev("p12", 0, 4, 16, 0);
      check_ev("p12", 1, 12, 16, 0);

      // ---------------- held high after one rise
      clear_events();
      @(negedge clk);
      rise_stamp.push_back(pcnt);
      pwm_in = 1'b1;
      hold(40, 1'b1);
      #1;
      check("hi_ndone", ev_duty.size(), 2);
      check_ev("hi", 0, 12, 16, 0);
      check_ev("hi", 1, 16, 0, 1);
      if (ev_stamp.size() >= 2) check("hi_gap", ev_stamp[1] - ev_stamp[0], 32);
      check("hi_stuck", int'(stuck), 1);

      // ---------------- recovery: arm then report, stuck clears
      clear_events();
      hold(4, 1'b0);
      repeat (2) pwm_period(16, 4, -1);
      #1;
      check("rec_ndone", ev_duty.size(), 1);
      check_ev("rec", 0, 4, 16, 0);
      check("rec_stuck", int'(stuck), 0);

      // ---------------- reset 7 cycles into a period
      clear_events();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         pwm_in = (c < 4);
      end
      @(negedge clk);
      #1;
      check("pre_duty", int'(duty_out), 4);
      reset  = 1'b1;
      pwm_in = 1'b0;
      #1;
      check("rs_duty",   int'(duty_out),   0);
      check("rs_period", int'(period_out), 0);
      check("rs_done",   int'(done),       0);
      check("rs_stuck",  int'(stuck),      0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      clear_events();
      repeat (2) pwm_period(16, 4, -1);
      #1;
      check("ar_ndone", ev_duty.size(), 1);
      check_ev("ar", 0, 4, 16, 0);

      // ---------------- 1-cycle glitch in the low phase
      clear_events();
      pwm_period(16, 4, 10);
      pwm_period(16, 4, -1);
      pwm_period(16, 4, -1);
      #1;
      if (FILT) begin
         check("gl_ndone", ev_duty.size(), 3);
         check_ev("gl", 0, 4, 16, 0);
         check_ev("gl", 1, 4, 16, 0);
         check_ev("gl", 2, 4, 16, 0);
      end else begin
         check("gl_ndone", ev_duty.size(), 4);
         check_ev("gl", 0, 4, 16, 0);
         check_ev("gl", 1, 4, 10, 0);
         check_ev("gl", 2, 1, 6, 0);
         check_ev("gl", 3, 4, 16, 0);
      end
      check("gl_duty",   int'(duty_out),   4);
      check("gl_period", int'(period_out), 16);

      check("done_width", wide_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
